// File: rtl/bullet_manager_pkg.sv
// Shared constants, OAM entry layout and helpers for the bullet manager.
package bullet_pkg;

    localparam int OAM_DEPTH   = 16;
    localparam int IDX_W       = $clog2(OAM_DEPTH);
    localparam int CNT_W       = IDX_W + 1;
    localparam int SPEED       = 2;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int TILE_WIDTH  = 8;
    localparam int TILE_HEIGHT = 8;

    localparam logic [10:0] SPEED_C = 11'(SPEED);
    localparam logic [10:0] X_MAX_C = 11'(SCREEN_W - TILE_WIDTH);
    localparam logic [10:0] Y_MAX_C = 11'(SCREEN_H - TILE_HEIGHT);

    localparam int ENABLE_BIT = 28;
    localparam int POSX_MSB   = 27;
    localparam int POSX_LSB   = 18;
    localparam int POSY_MSB   = 17;
    localparam int POSY_LSB   = 8;
    localparam int ROW_MSB    = 5;
    localparam int ROW_LSB    = 3;
    localparam int COL_MSB    = 2;
    localparam int COL_LSB    = 0;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0] rsvd_hi;
        logic       enable;
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] rsvd_lo;
        logic [2:0] row;
        logic [2:0] col;
    } bullet_entry_t;

    function automatic bullet_entry_t make_entry(input logic [9:0] x, input logic [9:0] y,
                                                 input logic [2:0] owner, input dir_t dir);
        bullet_entry_t e;
        e        = '0;
        e.enable = 1'b1;
        e.x      = x;
        e.y      = y;
        e.row    = owner;
        e.col    = {1'b0, dir};
        return e;
    endfunction

endpackage

// File: rtl/bullet_manager_if.sv
// Fire / kill request bundle between tank+collision logic and the bullet manager.
interface bullet_manager_if;
    import bullet_pkg::*;

    logic             fire_valid;
    logic             fire_ready;
    logic [9:0]       fire_x;
    logic [9:0]       fire_y;
    logic [1:0]       fire_dir;
    logic [2:0]       fire_owner;
    logic             kill_valid;
    logic [IDX_W-1:0] kill_idx;

    modport master (
        output fire_valid, fire_x, fire_y, fire_dir, fire_owner, kill_valid, kill_idx,
        input  fire_ready
    );

    modport slave (
        input  fire_valid, fire_x, fire_y, fire_dir, fire_owner, kill_valid, kill_idx,
        output fire_ready
    );
endinterface

// File: rtl/bullet_manager_slot_alloc.sv
// Lowest-index free slot finder over the OAM enable vector.
module bullet_slot_alloc
    import bullet_pkg::*;
(
    input  logic [OAM_DEPTH-1:0] en_i,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_free_o
);

    // Scan high to low so the lowest free index is the last one written.
    always_comb begin
        idx_o      = '0;
        any_free_o = 1'b0;
        for (int i = OAM_DEPTH - 1; i >= 0; i--) begin
            if (!en_i[i]) begin
                idx_o      = IDX_W'(i);
                any_free_o = 1'b1;
            end else begin
                any_free_o = any_free_o;
            end
        end
    end

endmodule

// File: rtl/bullet_manager.sv
// Bullet OAM owner: allocates slots on fire, sweeps all slots once per frame,
// retires off-screen or collided bullets and keeps a live-bullet count.
module bullet_manager
    import bullet_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_tick_i,
    bullet_manager_if.slave             bus,
    output logic [OAM_DEPTH-1:0][31:0]  oam_data_o,
    output logic [CNT_W-1:0]            active_count_o,
    output logic                        busy_o
);

    state_t                          state_q, state_d;
    logic          [IDX_W-1:0]       idx_q, idx_d;
    bullet_entry_t [OAM_DEPTH-1:0]   oam_q, oam_d;
    logic          [CNT_W-1:0]       count_q, count_d;

    logic [OAM_DEPTH-1:0] en_s;
    logic [IDX_W-1:0]     free_idx_s;
    logic                 any_free_s;
    logic                 fire_acc_s;
    logic                 kill_hit_s;
    logic                 sweep_hit_s;
    logic                 retire_s;
    logic                 sweep_ret_s;
    bullet_entry_t        cur_s;
    bullet_entry_t        moved_s;

    // Enable vector feeding the allocator.
    always_comb begin
        en_s = '0;
        for (int i = 0; i < OAM_DEPTH; i++) begin
            en_s[i] = oam_q[i].enable;
        end
    end

    bullet_slot_alloc u_alloc (
        .en_i       (en_s),
        .idx_o      (free_idx_s),
        .any_free_o (any_free_s)
    );

    assign bus.fire_ready = !rst && (state_q == ST_IDLE) && (count_q < CNT_W'(OAM_DEPTH));
    assign fire_acc_s     = bus.fire_valid && bus.fire_ready && any_free_s;
    assign kill_hit_s     = bus.kill_valid && oam_q[bus.kill_idx].enable;

    // Next-state logic for the IDLE/SWEEP controller.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_tick_i) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end else begin
                    idx_d   = idx_q;
                end
            end
            ST_SWEEP: begin
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(OAM_DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SWEEP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Single sweep step; bounds are checked at 11 bits so underflow/overflow never wraps.
    always_comb begin
        cur_s    = oam_q[idx_q];
        moved_s  = cur_s;
        retire_s = 1'b0;
        case (dir_t'(cur_s.col[1:0]))
            DIR_UP: begin
                if ({1'b0, cur_s.y} < SPEED_C) retire_s = 1'b1;
                else moved_s.y = cur_s.y - 10'(SPEED);
            end
            DIR_RIGHT: begin
                if (({1'b0, cur_s.x} + SPEED_C) > X_MAX_C) retire_s = 1'b1;
                else moved_s.x = cur_s.x + 10'(SPEED);
            end
            DIR_DOWN: begin
                if (({1'b0, cur_s.y} + SPEED_C) > Y_MAX_C) retire_s = 1'b1;
                else moved_s.y = cur_s.y + 10'(SPEED);
            end
            DIR_LEFT: begin
                if ({1'b0, cur_s.x} < SPEED_C) retire_s = 1'b1;
                else moved_s.x = cur_s.x - 10'(SPEED);
            end
            default: retire_s = 1'b0;
        endcase
    end

    assign sweep_hit_s = (state_q == ST_SWEEP) && cur_s.enable;
    assign sweep_ret_s = sweep_hit_s && retire_s && !(kill_hit_s && (bus.kill_idx == idx_q));

    // OAM and count update; kill is applied last so it overrides the sweep.
    always_comb begin
        oam_d = oam_q;
        if (sweep_hit_s) begin
            oam_d[idx_q] = retire_s ? bullet_entry_t'('0) : moved_s;
        end else begin
            oam_d[idx_q] = oam_q[idx_q];
        end
        if (fire_acc_s) begin
            oam_d[free_idx_s] = make_entry(bus.fire_x, bus.fire_y, bus.fire_owner,
                                           dir_t'(bus.fire_dir));
        end else begin
            oam_d[free_idx_s] = oam_d[free_idx_s];
        end
        if (kill_hit_s) begin
            oam_d[bus.kill_idx] = '0;
        end else begin
            oam_d[bus.kill_idx] = oam_d[bus.kill_idx];
        end
        count_d = count_q + CNT_W'(fire_acc_s) - CNT_W'(kill_hit_s) - CNT_W'(sweep_ret_s);
    end

    // State, sweep index, OAM and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            oam_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            oam_q   <= oam_d;
            count_q <= count_d;
        end
    end

    assign oam_data_o     = oam_q;
    assign active_count_o = count_q;
    assign busy_o         = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_bullet_manager.sv
// Directed self-checking bench for bullet_manager.
module tb_bullet_manager;
    import bullet_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       frame_tick;
    logic [OAM_DEPTH-1:0][31:0] oam;
    logic [CNT_W-1:0]           cnt;
    logic                       busy;
    int                         checks = 0;
    int                         errors = 0;
    int                         n;
    logic                       rdy_seen;

    bullet_manager_if bus();

    bullet_manager dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick_i   (frame_tick),
        .bus            (bus),
        .oam_data_o     (oam),
        .active_count_o (cnt),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fire_set(input logic [9:0] x, input logic [9:0] y,
                            input logic [1:0] dir, input logic [2:0] owner);
        bus.fire_valid = 1'b1;
        bus.fire_x     = x;
        bus.fire_y     = y;
        bus.fire_dir   = dir;
        bus.fire_owner = owner;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
    endtask

    task automatic sweep_wait(output int cycles, output logic ready_seen);
        cycles     = 0;
        ready_seen = 1'b0;
        while (busy === 1'b1 && cycles < 40) begin
            if (bus.fire_ready !== 1'b0) ready_seen = 1'b1;
            cycles++;
            tick();
        end
    endtask

    task automatic pulse_sweep();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        sweep_wait(n, rdy_seen);
        chk("sweep_len", 32'(n), 32'd16);
    endtask

    initial begin
        rst            = 1'b1;
        frame_tick     = 1'b0;
        bus.fire_valid = 1'b0;
        bus.fire_x     = '0;
        bus.fire_y     = '0;
        bus.fire_dir   = '0;
        bus.fire_owner = '0;
        bus.kill_valid = 1'b0;
        bus.kill_idx   = '0;
        #2;
        chk("rst_oam0", oam[0], 32'h0);
        chk("rst_oam15", oam[15], 32'h0);
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(bus.fire_ready), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 32'(bus.fire_ready), 32'd1);

        // Basic fire and entry format.
        fire_set(10'd100, 10'd200, 2'd1, 3'd2);
        tick();
        bus.fire_valid = 1'b0;
        chk("fire_entry", oam[0], 32'h1190_C811);
        chk("fire_count", 32'(cnt), 32'd1);
        bus.kill_valid = 1'b1;
        bus.kill_idx   = 4'd0;
        tick();
        bus.kill_valid = 1'b0;
        chk("kill_slot0", oam[0], 32'h0);
        chk("kill_count", 32'(cnt), 32'd0);

        // Right-moving bullet at the right edge.
        fire_set(10'd630, 10'd100, 2'd1, 3'd0);
        tick();
        bus.fire_valid = 1'b0;
        pulse_sweep();
        chk("right_632", oam[0], 32'h19E0_6401);
        chk("right_cnt1", 32'(cnt), 32'd1);
        pulse_sweep();
        chk("right_retire", oam[0], 32'h0);
        chk("right_cnt0", 32'(cnt), 32'd0);

        // Up bullet at y=1 and left bullet at x=1 both retire without wrapping.
        fire_set(10'd50, 10'd1, 2'd0, 3'd3);
        tick();
        fire_set(10'd1, 10'd50, 2'd3, 3'd0);
        tick();
        bus.fire_valid = 1'b0;
        chk("two_live", 32'(cnt), 32'd2);
        pulse_sweep();
        chk("up_retire", oam[0], 32'h0);
        chk("left_retire", oam[1], 32'h0);
        chk("edge_cnt0", 32'(cnt), 32'd0);

        // Fill every slot.
        fire_set(10'd10, 10'd20, 2'd2, 3'd1);
        for (int i = 0; i < 16; i++) tick();
        chk("full_count", 32'(cnt), 32'd16);
        chk("full_ready", 32'(bus.fire_ready), 32'd0);
        chk("full_slot0", oam[0], 32'h1028_140A);
        chk("full_slot15", oam[15], 32'h1028_140A);
        tick();
        chk("full_hold", 32'(cnt), 32'd16);
        bus.kill_valid = 1'b1;
        bus.kill_idx   = 4'd5;
        tick();
        bus.kill_valid = 1'b0;
        chk("kill5_count", 32'(cnt), 32'd15);
        chk("kill5_slot", oam[5], 32'h0);
        fire_set(10'd300, 10'd40, 2'd3, 3'd7);
        tick();
        bus.fire_valid = 1'b0;
        chk("refill_slot5", oam[5], 32'h14B0_283B);
        chk("refill_count", 32'(cnt), 32'd16);

        // Kill and fire together: allocation uses the pre-kill free map.
        bus.kill_valid = 1'b1;
        bus.kill_idx   = 4'd7;
        tick();
        bus.kill_idx   = 4'd3;
        fire_set(10'd300, 10'd40, 2'd3, 3'd7);
        tick();
        bus.kill_valid = 1'b0;
        bus.fire_valid = 1'b0;
        chk("kf_slot7", oam[7], 32'h14B0_283B);
        chk("kf_slot3", oam[3], 32'h0);
        chk("kf_count", 32'(cnt), 32'd15);

        // Async reset clears immediately.
        rst = 1'b1;
        #1;
        chk("async_rst_slot0", oam[0], 32'h0);
        chk("async_rst_count", 32'(cnt), 32'd0);
        tick();
        rst = 1'b0;

        // Fire together with frame_tick.
        fire_set(10'd100, 10'd200, 2'd1, 3'd2);
        frame_tick = 1'b1;
        tick();
        bus.fire_valid = 1'b0;
        frame_tick     = 1'b0;
        chk("ft_fire_entry", oam[0], 32'h1190_C811);
        chk("ft_busy", 32'(busy), 32'd1);
        sweep_wait(n, rdy_seen);
        chk("ft_busy_len", 32'(n), 32'd16);
        chk("ft_ready_low", 32'(rdy_seen), 32'd0);
        chk("ft_moved", oam[0], 32'h1198_C811);

        // Kill racing the sweep on slot 3; extra frame_tick mid-sweep is dropped.
        do_reset();
        fire_set(10'd10, 10'd20, 2'd2, 3'd1);
        for (int i = 0; i < 4; i++) tick();
        bus.fire_valid = 1'b0;
        chk("race_cnt4", 32'(cnt), 32'd4);
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        tick();
        tick();
        tick();
        bus.kill_valid = 1'b1;
        bus.kill_idx   = 4'd3;
        tick();
        bus.kill_valid = 1'b0;
        frame_tick     = 1'b1;
        tick();
        frame_tick = 1'b0;
        chk("race_slot3", oam[3], 32'h0);
        chk("race_cnt3", 32'(cnt), 32'd3);
        sweep_wait(n, rdy_seen);
        chk("race_rest_len", 32'(n), 32'd11);
        chk("race_slot0", oam[0], 32'h1028_160A);
        chk("race_slot2", oam[2], 32'h1028_160A);
        chk("race_cnt_end", 32'(cnt), 32'd3);
        tick();
        chk("dropped_tick", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
